// File: rtl/serial_subtractor_if.sv
// Controller-facing handshake and operand bundle for serial_subtractor.
// Carries the mode bit only when SERIAL_SUB_ADD_MODE_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             mode;

    modport master (
        output start, a, b, bin, mode,
        input  busy, done, diff, bout
    );
    modport slave (
        input  start, a, b, bin, mode,
        output busy, done, diff, bout
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock, start/busy/done.
// SERIAL_SUB_ADD_MODE_EN adds a mode input selecting a + b + cin instead.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bo_r;
    logic             x;
    logic             y;
    logic             d;
    logic             br_nxt;
    logic             last;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             add_r;
`endif

    always_comb begin
        x    = a_sh[0];
        y    = b_sh[0];
        d    = x ^ y ^ br;
        last = (cnt == CW'(WIDTH - 1));
`ifdef SERIAL_SUB_ADD_MODE_EN
        // br doubles as the carry when adding
        if (add_r)
            br_nxt = (x & y) | ((x ^ y) & br);
        else
            br_nxt = (~x & y) | (~(x ^ y) & br);
`else
        br_nxt = (~x & y) | (~(x ^ y) & br);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.start) nxt = SHIFT;
            SHIFT:   if (last) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            d_sh <= '0;
            cnt  <= '0;
            br   <= 1'b0;
            bo_r <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            add_r <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (bus.start) begin
                a_sh <= bus.a;
                b_sh <= bus.b;
                br   <= bus.bin;
                cnt  <= '0;
                d_sh <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                add_r <= bus.mode;
`endif
            end
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            d_sh <= {d, d_sh[WIDTH-1:1]};
            br   <= br_nxt;
            cnt  <= cnt + CW'(1);
            if (last)
                bo_r <= br_nxt;
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.diff = d_sh;
    assign bus.bout = bo_r;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
- Uses a full-subtractor cell and a registered borrow flip-flop.
- Sequential counterpart to the combinational full-adder cell. Used in the processor datapath where area matters more than latency.
- Simple start/busy/done handshake toward the controller.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk     input   1      single clock, all state updates on rising edge
rst     input   1      asynchronous, active-high reset
start   input   1      request; sampled only in IDLE
a       input   WIDTH  minuend; captured on the accepting edge
b       input   WIDTH  subtrahend; captured on the accepting edge
bin     input   1      borrow-in; captured on the accepting edge
busy    output  1      high while bits are being processed
done    output  1      one-cycle pulse when result is valid
diff    output  WIDTH  result; held stable from done until next accepted start
bout    output  1      final borrow-out; held with diff

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow FF and bit counter cleared.
- States:
  - IDLE: start=1 at an edge moves to SHIFT. That edge loads a_sh=a, b_sh=b, br=bin, cnt=0, clears the diff shift register and sets busy=1.
  - SHIFT: each edge processes bit x=a_sh[0], y=b_sh[0]:
    - d = x^y^br
    - br <= (~x&y) | (~(x^y)&br)
    - d shifted into diff MSB; diff shifts right; a_sh and b_sh shift right; cnt++.
  - SHIFT exit: on the edge processing cnt==WIDTH-1, go to DONE with busy=0, done=1, bout=final br.
  - DONE: lasts exactly one cycle, then returns to IDLE with done=0.
- Latency: accepting edge E0. Bits processed on E1..EWIDTH. done high for the cycle following EWIDTH, i.e. WIDTH+1 edges after the start edge.
- Boundary conditions:
  - start in SHIFT or DONE is ignored; no queuing.
  - start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
  - a, b, bin may change freely after the accepting edge without effect.
  - diff/bout hold their value in IDLE until the next accepted start. Then diff clears and bout keeps its old value until done.
  - Wrap-around: a<b gives the two's-complement result modulo 2^WIDTH with bout=1. Example: 0 - 0 - 1 gives all-ones with bout=1.
  - busy and done are never high in the same cycle.

Optional Feature:
- Macro: SERIAL_SUB_ADD_MODE_EN.
- When defined:
  - Extra input port mode (1 bit), captured with the operands on the accepting edge.
  - mode=1 selects addition: bin acts as carry-in, the serial cell computes the full-adder carry c <= x&y | (x^y)&c, and bout reports carry-out.
  - mode=0 behaves exactly as subtraction.
- When undefined:
  - Port mode is absent.
  - Block always subtracts, with identical timing.

Test Plan:
- WIDTH=8, a=0x0A, b=0x03, bin=0, start pulse -> busy high for 8 cycles; done high on the 9th cycle after the start edge; diff=0x07, bout=0.
- a=0x03, b=0x0A, bin=0 -> diff=0xF9, bout=1; values held in IDLE for 5 cycles afterward.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0x80, b=0x80, bin=0 -> diff=0x00, bout=0.
- Start 0x55-0x11, then pulse start with 0xFF/0x00 during cycle 3 of SHIFT -> second request ignored; diff=0x44, done exactly once.
- Assert rst asynchronously, mid-clock, after bit 4 of 0xF0-0x0F -> busy, done, diff, bout all 0 immediately. Then a fresh 0x20-0x01 -> diff=0x1F, bout=0.
- With SERIAL_SUB_ADD_MODE_EN: mode=1, a=0xFF, b=0x01, bin=0 -> diff=0x00, bout=1. Then mode=0 with the same operands -> diff=0xFE, bout=0.
